mem_access_ctrl: RTL
====================

# mem_access_ctrl

Memory-access sequencer between the control unit, the MAR/MDR pair and the synchronous main memory. On a read or write command it presents the latched MAR address to memory, waits for the memory ready handshake (with timeout), and then either returns read data toward the MDR input mux with a one-cycle load strobe, or completes the write of the MDR contents. It is the stage that produces the MDR's memory-side data input and its read-select and load controls.

## Interface

- ADDR_W, 9, memory word-address width (512 words)
- TIMEOUT, 15, maximum cycles spent in ACCESS without mem_ready before abort (range 1..255)

- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- read_req  in  1  control-unit memory read command, level
- write_req  in  1  control-unit memory write command, level
- mar_q  in  ADDR_W  address from MAR
- mdr_q  in  32  data from MDR (write source)
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid when mem_ready=1
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable (meaningful only with mem_en)
- mem_ready  in  1  memory completion handshake
- mdata_in  out  32  registered read data toward the MDR input mux
- mdr_read  out  1  MDR mux select: 1 = memory side
- mdr_load  out  1  one-cycle MDR load strobe
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle timeout pulse

## Operation

- States: IDLE, ACCESS, COMPLETE.
- IDLE: read_req or write_req is sampled on the clock edge. Read has priority when both are high; the write is dropped, not queued. On accept:
  - latch mar_q into the address register;
  - on a write, latch mdr_q into the write-data register;
  - latch the op type;
  - clear the wait counter;
  - go to ACCESS.
- ACCESS:
  - mem_en=1 and mem_addr = latched address;
  - on a write, mem_we=1 and mem_wdata = latched data;
  - mdr_read=1 on a read.
  - If mem_ready=1: on a read, capture mem_rdata into mdata_in; go to COMPLETE.
  - Otherwise the wait counter increments. If the counter reaches TIMEOUT-1 with mem_ready still 0, go to IDLE with err=1 for one cycle, no done, no mdr_load, and mdata_in unchanged.
- COMPLETE:
  - mem_en=0; done=1;
  - on a read, mdr_read=1 and mdr_load=1;
  - go to IDLE unconditionally.
- mdata_in holds its value until the next successful read.
- Requests are ignored outside IDLE. A request still high when IDLE is re-entered starts a new access at the next edge, so the control unit deasserts its request on done or err.
- mar_q and mdr_q changing after accept do not affect the access in progress.
- mem_wdata is driven 0 when not writing. mem_addr holds the latched address.

## Timing

- Reset (asynchronous, any state): state=IDLE and the wait counter is cleared. All outputs go to 0 immediately: mem_en, mem_we, mdr_read, mdr_load, busy, done, err, mem_addr, mem_wdata, mdata_in. An access interrupted by reset produces no done or err.
- Request high before edge E0 → ACCESS from E0, with mem_en high in the cycle after E0.
- Zero-wait memory (mem_ready high in the first ACCESS cycle) → COMPLETE after E1. done and mdr_load are high between E1 and E2, so the MDR captures mdata_in at E2. The total is 3 edges from request to MDR loaded.
- Each wait cycle adds one cycle of latency.
- Timeout: after TIMEOUT cycles in ACCESS without ready, err is high for the cycle following the last ACCESS cycle, and busy=0 in that cycle.
- mem_ready arriving in the same cycle as the timeout limit counts as success: ready wins.
- mem_ready outside ACCESS is ignored.
- done and err are never high together.
- Back-to-back accesses: minimum spacing is 3 cycles (IDLE, ACCESS, COMPLETE).

## Test plan

- Reset with mem_en active mid-ACCESS → all outputs 0 without a clock edge. The next read_req starts cleanly in ACCESS.
- Read with mar_q=0x045, mem_ready=1 on the first ACCESS cycle, mem_rdata=0xDEADBEEF → mdata_in=0xDEADBEEF. mdr_read=1 for 2 cycles. mdr_load and done pulse once, 2 edges after accept.
- Write with mar_q=0x1FF, mdr_q=0x12345678, and mdr_q changed to 0 after accept, mem_ready after 3 waits → mem_we=1 and mem_wdata=0x12345678 for 4 cycles. done=1, mdr_load=0, mdata_in unchanged.
- Read with mem_ready never asserted, TIMEOUT=15 → exactly 15 ACCESS cycles, then err=1 for one cycle, no done or mdr_load, and state returns to IDLE.
- read_req and write_req high together → only a read occurs (mem_we stays 0). With both held high, the next read starts exactly 3 cycles after the first.
- mem_ready pulsed while in IDLE, and again on the 15th ACCESS cycle → the IDLE pulse is ignored. The 15th-cycle ready completes normally with done=1 and err=0.

Source files
------------

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mem_access_ctrl                                                        |
// | Sequences MAR/MDR memory reads and writes with ready/timeout handling. |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module mem_access_ctrl #(
   parameter int ADDR_W  = 9,
   parameter int TIMEOUT = 15
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              read_req,
   input  logic              write_req,
   input  logic [ADDR_W-1:0] mar_q,
   input  logic [31:0]       mdr_q,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   output logic              mem_en,
   output logic              mem_we,
   input  logic              mem_ready,
   output logic [31:0]       mdata_in,
   output logic              mdr_read,
   output logic              mdr_load,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_ACCESS   = 2'd1,
      S_COMPLETE = 2'd2
   } state_t;

   localparam logic [7:0] c_wait_last = 8'(TIMEOUT - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic [31:0]       r_rdata;
   logic              r_is_read;
   logic              r_err;
   logic [7:0]        r_wait_cnt;
   logic              w_accept;
   logic              w_timeout;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Ready is tested before the wait limit so a last-cycle ready still succeeds.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (read_req || write_req) begin
               w_accept    = 1'b1;
               w_state_nxt = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (mem_ready) begin
               w_state_nxt = S_COMPLETE;
            end else if (r_wait_cnt == c_wait_last) begin
               w_timeout   = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         S_COMPLETE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_addr     <= '0;
         r_wdata    <= '0;
         r_rdata    <= '0;
         r_is_read  <= 1'b0;
         r_err      <= 1'b0;
         r_wait_cnt <= '0;
      end else begin
         r_err <= w_timeout;
         if (w_accept) begin
            r_addr     <= mar_q;
            r_is_read  <= read_req;
            r_wait_cnt <= '0;
            if (!read_req) begin
               r_wdata <= mdr_q;
            end
         end else if (r_state == S_ACCESS) begin
            if (mem_ready) begin
               if (r_is_read) begin
                  r_rdata <= mem_rdata;
               end
            end else if (!w_timeout) begin
               r_wait_cnt <= r_wait_cnt + 8'd1;
            end
         end
      end
   end

   assign mem_en    = (r_state == S_ACCESS);
   assign mem_we    = mem_en && !r_is_read;
   assign mem_wdata = mem_we ? r_wdata : 32'd0;
   assign mem_addr  = r_addr;
   assign mdata_in  = r_rdata;
   assign mdr_read  = r_is_read && (r_state == S_ACCESS || r_state == S_COMPLETE);
   assign mdr_load  = r_is_read && (r_state == S_COMPLETE);
   assign busy      = (r_state != S_IDLE);
   assign done      = (r_state == S_COMPLETE);
   assign err       = r_err;

endmodule
`default_nettype wire
